// File: rtl/hier_skid_stage_if.sv
// Valid/ready handshake bundle for hier_skid_stage.
// Both sides of the stage are carried here. The master modport is the
// environment: upstream producer plus downstream consumer. The slave modport
// is the stage itself.
interface hier_skid_stage_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/hier_skid_stage.sv
// hier_skid_stage: registered 2-entry skid buffer with valid/ready on both sides.
// Every output comes straight from a flop. There is no combinational path from
// in_* to out_*, or from out_ready to in_ready.
// Optional: define HIER_SKID_STAGE_OCCUPANCY_EN to add a registered 2-bit
// occupancy output (0=EMPTY, 1=ONE, 2=TWO).
module hier_skid_stage #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hier_skid_stage_if.slave     bus
`ifdef HIER_SKID_STAGE_OCCUPANCY_EN
  ,
  output logic [1:0]           occupancy
`endif
);

  // The state encoding is also the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic w_accept;
  logic w_send;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_send   = r_out_valid & bus.out_ready;

  // FSM: the state, the handshake flags and both data registers update on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main      <= RESET_DATA;
      r_skid      <= RESET_DATA;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main      <= bus.in_data;
            r_out_valid <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_send) begin
            r_main <= bus.in_data;
          end else if (w_send) begin
            r_out_valid <= 1'b0;
            r_state     <= S_EMPTY;
          end else if (w_accept) begin
            // The main register is still waiting to drain, so park the new word.
            r_skid     <= bus.in_data;
            r_in_ready <= 1'b0;
            r_state    <= S_TWO;
          end
        end
        S_TWO: begin
          // in_ready is low here, so nothing can be accepted. Only draining happens.
          if (w_send) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= S_ONE;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_data  = r_main;

`ifdef HIER_SKID_STAGE_OCCUPANCY_EN
  assign occupancy = r_state;
`endif

endmodule

// File: tb/tb_hier_skid_stage.sv
// Self-checking bench for hier_skid_stage. The reference is a bounded queue of
// in-flight words. A word enters the queue on accept and leaves it on send.
module tb_hier_skid_stage;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  hier_skid_stage_if #(.WIDTH(W)) bus ();
`ifdef HIER_SKID_STAGE_OCCUPANCY_EN
  logic [1:0] occ;
`endif

  hier_skid_stage #(.WIDTH(W), .RESET_DATA(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef HIER_SKID_STAGE_OCCUPANCY_EN
    ,
    .occupancy (occ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the FIFO contents, plus the value out_data shows when the FIFO is empty.
  logic [W-1:0] q[$];
  logic [W-1:0] hold;
  bit           last_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(q.size() > 0));
    chk({tag, ".in_ready"},  64'(bus.in_ready),  64'(q.size() < 2));
    chk({tag, ".out_data"},  64'(bus.out_data),  64'((q.size() > 0) ? q[0] : hold));
`ifdef HIER_SKID_STAGE_OCCUPANCY_EN
    chk({tag, ".occupancy"}, 64'(occ), 64'(q.size()));
`endif
  endtask

  // One clock cycle: drive the inputs, take the edge, advance the model, then check.
  task automatic cyc(input string tag, input bit v, input logic [W-1:0] d, input bit r);
    bit acc, snd;
    bus.in_valid  = v;
    bus.in_data   = v ? d : 'x;
    bus.out_ready = r;
    acc = v && (q.size() < 2);
    snd = r && (q.size() > 0);
    @(posedge clk);
    if (snd) hold = q.pop_front();
    if (acc) q.push_back(d);
    last_acc = acc;
    #1;
    check_outs(tag);
  endtask

  // Hold one word on in_valid until it is accepted. The out_ready pattern toggles if alt is set.
  task automatic push_word(input string tag, input logic [W-1:0] d, input bit alt, inout bit r);
    int n;
    n = 0;
    do begin
      cyc(tag, 1'b1, d, r);
      if (alt) r = ~r;
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) chk({tag, ".accept_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4; i++) cyc(tag, 1'b0, '0, 1'b1);
  endtask

  initial begin
    bit r;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    hold  = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_outs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) cyc("idle", 1'b0, '0, 1'b1);

    // Single transfer.
    cyc("single", 1'b1, 8'hA5, 1'b1);
    cyc("single", 1'b0, '0, 1'b1);
    cyc("single", 1'b0, '0, 1'b1);

    // Streaming at one word per cycle.
    for (int i = 1; i <= 16; i++) cyc("stream", 1'b1, W'(i), 1'b1);
    drain("stream");

    // Back-pressure: 0x33 stays on in_valid until the stage accepts it.
    r = 1'b0;
    push_word("bp", 8'h11, 1'b0, r);
    push_word("bp", 8'h22, 1'b0, r);
    cyc("bp_full", 1'b1, 8'h33, 1'b0);
    cyc("bp_full", 1'b1, 8'h33, 1'b0);
    r = 1'b1;
    push_word("bp", 8'h33, 1'b0, r);
    drain("bp");

    // Alternating out_ready with continuous input.
    r = 1'b1;
    for (int i = 0; i < 16; i++) push_word("alt", W'(8'h40 + i), 1'b1, r);
    drain("alt");

    // Async reset while holding two words.
    r = 1'b0;
    push_word("fill", 8'h55, 1'b0, r);
    push_word("fill", 8'h66, 1'b0, r);
    #2 rst_n = 1'b0;
    q.delete();
    hold = 8'h00;
    #1 check_outs("async_rst");
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc("post_rst", 1'b0, '0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cyc("rand", bit'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 3) != 0);
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
